booth_mul: RTL

BOOTH_MUL -- requirements
Module: booth_mul

---
 rtl/booth_mul.sv | 115 +++++++++++
 1 files changed

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// One partial-product step per clock; result registered on the DONE cycle.
module booth_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    // Accumulator and multiplicand carry one guard bit so -2^(WIDTH-1) negates cleanly.
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and busy flag.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Booth recoding of {Q[0], Q_-1}: add M, subtract M, or pass through.
    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc + ~m + 1'b1;
            default: sum = acc;
        endcase
    end

    // Datapath: load operands, step add/shift, then publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            m       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= {a[WIDTH-1], a};
                        q     <= b;
                        q_m1  <= 1'b0;
                        acc   <= '0;
                        count <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    acc   <= {sum[WIDTH], sum[WIDTH:1]};
                    q     <= {sum[0], q[WIDTH-1:1]};
                    q_m1  <= q[0];
                    count <= count - 1'b1;
                end
                DONE: begin
                    product <= {acc[WIDTH-1:0], q};
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
